// File: rtl/switch_cfg_ctrl.sv
// Break-before-make shadow/active connection map controller for a 16x16 switch.
// Optional readback of the active map when SWITCH_CFG_READBACK_EN is defined.
module switch_cfg_ctrl #(
  parameter int BLANK_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [3:0]  cfg_port,
  input  logic [3:0]  cfg_src,
  input  logic        cfg_en,
  input  logic        commit,
  output logic        commit_done,
  output logic [63:0] sel_bus,
`ifdef SWITCH_CFG_READBACK_EN
  input  logic [3:0]  rd_port,
  output logic [3:0]  rd_src,
  output logic        rd_en,
`endif
  output logic [15:0] oe_bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    APPLY = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [15:0][3:0] sh_src_q, sh_src_d;
  logic [15:0]      sh_en_q, sh_en_d;
  logic [15:0][3:0] act_src_q, act_src_d;
  logic [15:0]      act_en_q, act_en_d;
  logic [15:0]      mask_q, mask_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [63:0]      sel_q, sel_d;
  logic [15:0]      oe_q, oe_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             wr;

  function automatic logic [3:0] gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sh_src_q  <= '0;
      sh_en_q   <= '0;
      act_src_q <= '0;
      act_en_q  <= '0;
      mask_q    <= '0;
      cnt_q     <= '0;
      sel_q     <= '0;
      oe_q      <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_src_q  <= sh_src_d;
      sh_en_q   <= sh_en_d;
      act_src_q <= act_src_d;
      act_en_q  <= act_en_d;
      mask_q    <= mask_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      oe_q      <= oe_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (commit) state_d = BLANK;
      BLANK:   if (cnt_q == 4'd0) state_d = APPLY;
      APPLY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr        = cfg_valid && ready_q;
    sh_src_d  = sh_src_q;
    sh_en_d   = sh_en_q;
    act_src_d = act_src_q;
    act_en_d  = act_en_q;
    mask_d    = mask_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    oe_d      = oe_q;
    done_d    = 1'b0;
    ready_d   = (state_d == IDLE);
    if (wr) begin
      sh_src_d[cfg_port] = cfg_src;
      sh_en_d[cfg_port]  = cfg_en;
    end
    unique case (state_q)
      IDLE: begin
        if (commit) begin
          // compare against the shadow including this cycle's write
          for (int k = 0; k < 16; k++) begin
            mask_d[k] = act_en_q[k] &&
                        ((sh_src_d[k] != act_src_q[k]) ||
                         (sh_en_d[k] != act_en_q[k]));
          end
          cnt_d = 4'(BLANK_CYCLES - 1);
          oe_d  = act_en_q & ~mask_d;
        end
      end
      BLANK: begin
        if (cnt_q == 4'd0) begin
          for (int k = 0; k < 16; k++) begin
            sel_d[4*k +: 4] = gray(sh_src_q[k]);
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      APPLY: begin
        act_src_d = sh_src_q;
        act_en_d  = sh_en_q;
        oe_d      = sh_en_q;
        done_d    = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef SWITCH_CFG_READBACK_EN
  logic [3:0] rd_src_q;
  logic       rd_en_q;

  // reads the next active value so the update shows from the IDLE return
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_src_q <= '0;
      rd_en_q  <= 1'b0;
    end else begin
      rd_src_q <= act_src_d[rd_port];
      rd_en_q  <= act_en_d[rd_port];
    end
  end

  assign rd_src = rd_src_q;
  assign rd_en  = rd_en_q;
`endif

  assign cfg_ready   = ready_q;
  assign commit_done = done_q;
  assign sel_bus     = sel_q;
  assign oe_bus      = oe_q;

endmodule

// File: tb/tb_switch_cfg_ctrl.sv
// Directed-vector bench for switch_cfg_ctrl (BLANK_CYCLES = 2).
// Readback checks compile in only with SWITCH_CFG_READBACK_EN.
module tb_switch_cfg_ctrl;

  logic        clk;
  logic        reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [3:0]  cfg_port;
  logic [3:0]  cfg_src;
  logic        cfg_en;
  logic        commit;
  logic        commit_done;
  logic [63:0] sel_bus;
  logic [15:0] oe_bus;
`ifdef SWITCH_CFG_READBACK_EN
  logic [3:0]  rd_port;
  logic [3:0]  rd_src;
  logic        rd_en;
`endif

  int vectors;
  int miscompares;

  switch_cfg_ctrl #(.BLANK_CYCLES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_port    (cfg_port),
    .cfg_src     (cfg_src),
    .cfg_en      (cfg_en),
    .commit      (commit),
    .commit_done (commit_done),
    .sel_bus     (sel_bus),
`ifdef SWITCH_CFG_READBACK_EN
    .rd_port     (rd_port),
    .rd_src      (rd_src),
    .rd_en       (rd_en),
`endif
    .oe_bus      (oe_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cfg(input logic [3:0] p, input logic [3:0] s,
                           input logic e);
    cfg_valid = 1'b1;
    cfg_port  = p;
    cfg_src   = s;
    cfg_en    = e;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    vectors++;
    if (sel_bus !== 64'h0 || oe_bus !== 16'h0 ||
        cfg_ready !== 1'b1 || commit_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: sel=%h oe=%h rdy=%b done=%b exp 0/0/1/0",
               sel_bus, oe_bus, cfg_ready, commit_done);
    end
    write_cfg(4'd3, 4'd10, 1'b1);
    step();
    step();
    vectors++;
    if (sel_bus !== 64'h0 || oe_bus !== 16'h0) begin
      miscompares++;
      $display("FAIL shadow_only: sel=%h oe=%h exp 0/0", sel_bus, oe_bus);
    end
  endtask

  task automatic test_commit_new();
    commit = 1'b1;
    step();
    commit = 1'b0;
    vectors++;
    if (cfg_ready !== 1'b0 || oe_bus !== 16'h0) begin
      miscompares++;
      $display("FAIL new_blank: rdy=%b oe=%h exp 0/0000", cfg_ready, oe_bus);
    end
    step();
    step();
    vectors++;
    if (sel_bus !== 64'h0000_0000_0000_F000 || oe_bus !== 16'h0) begin
      miscompares++;
      $display("FAIL new_apply: sel=%h oe=%h exp F000/0000", sel_bus, oe_bus);
    end
    step();
    vectors++;
    if (oe_bus !== 16'h0008 || commit_done !== 1'b1 || cfg_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL new_idle: oe=%h done=%b rdy=%b exp 0008/1/1",
               oe_bus, commit_done, cfg_ready);
    end
    step();
    vectors++;
    if (commit_done !== 1'b0) begin
      miscompares++;
      $display("FAIL new_done_pulse: done=%b exp 0", commit_done);
    end
  endtask

  task automatic test_break_before_make();
    write_cfg(4'd5, 4'd4, 1'b1);
    commit = 1'b1;
    step();
    commit = 1'b0;
    for (int i = 0; i < 4; i++) step();
    vectors++;
    if (sel_bus !== 64'h0000_0000_0060_F000 || oe_bus !== 16'h0028) begin
      miscompares++;
      $display("FAIL p5_setup: sel=%h oe=%h exp 60F000/0028", sel_bus, oe_bus);
    end
    write_cfg(4'd3, 4'd2, 1'b1);
    commit = 1'b1;
    step();
    commit = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      vectors++;
      if (oe_bus !== 16'h0020 || sel_bus[23:20] !== 4'b0110) begin
        miscompares++;
        $display("FAIL bbm_t%0d: oe=%h sel5=%b exp 0020/0110",
                 i, oe_bus, sel_bus[23:20]);
      end
      if (i < 3) step();
    end
    vectors++;
    if (sel_bus !== 64'h0000_0000_0060_3000) begin
      miscompares++;
      $display("FAIL bbm_sel: sel=%h exp 603000", sel_bus);
    end
    step();
    vectors++;
    if (oe_bus !== 16'h0028 || commit_done !== 1'b1) begin
      miscompares++;
      $display("FAIL bbm_idle: oe=%h done=%b exp 0028/1", oe_bus, commit_done);
    end
    step();
  endtask

  task automatic test_same_cycle();
    cfg_valid = 1'b1;
    cfg_port  = 4'd0;
    cfg_src   = 4'd15;
    cfg_en    = 1'b1;
    commit    = 1'b1;
    step();
    cfg_valid = 1'b0;
    commit    = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      vectors++;
      if (oe_bus !== 16'h0028) begin
        miscompares++;
        $display("FAIL same_oe_t%0d: oe=%h exp 0028", i, oe_bus);
      end
      if (i < 3) step();
    end
    vectors++;
    if (sel_bus !== 64'h0000_0000_0060_3008) begin
      miscompares++;
      $display("FAIL same_sel: sel=%h exp 603008", sel_bus);
    end
    step();
    vectors++;
    if (oe_bus !== 16'h0029 || commit_done !== 1'b1) begin
      miscompares++;
      $display("FAIL same_idle: oe=%h done=%b exp 0029/1", oe_bus, commit_done);
    end
    step();
  endtask

  task automatic test_last_write_wins();
    write_cfg(4'd7, 4'd1, 1'b1);
    write_cfg(4'd7, 4'd9, 1'b1);
    commit = 1'b1;
    step();
    commit = 1'b0;
    for (int i = 0; i < 4; i++) step();
    vectors++;
    if (sel_bus !== 64'h0000_0000_D060_3008 || oe_bus !== 16'h00A9) begin
      miscompares++;
      $display("FAIL last_wins: sel=%h oe=%h exp D0603008/00A9",
               sel_bus, oe_bus);
    end
  endtask

  task automatic test_no_change_commit();
    commit = 1'b1;
    step();
    commit = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      vectors++;
      if (oe_bus !== 16'h00A9 || sel_bus !== 64'h0000_0000_D060_3008) begin
        miscompares++;
        $display("FAIL nochg_t%0d: oe=%h sel=%h exp 00A9/D0603008",
                 i, oe_bus, sel_bus);
      end
      if (i < 4) step();
    end
    vectors++;
    if (commit_done !== 1'b1) begin
      miscompares++;
      $display("FAIL nochg_done: done=%b exp 1", commit_done);
    end
    step();
  endtask

  task automatic test_ignored_busy();
    commit = 1'b1;
    step();
    cfg_valid = 1'b1;
    cfg_port  = 4'd1;
    cfg_src   = 4'd3;
    cfg_en    = 1'b1;
    vectors++;
    if (cfg_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_ready: rdy=%b exp 0", cfg_ready);
    end
    step();
    step();
    step();
    cfg_valid = 1'b0;
    commit    = 1'b0;
    vectors++;
    if (commit_done !== 1'b1 || cfg_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_end: done=%b rdy=%b exp 1/1", commit_done, cfg_ready);
    end
    step();
    vectors++;
    if (cfg_ready !== 1'b1 || commit_done !== 1'b0 || oe_bus !== 16'h00A9) begin
      miscompares++;
      $display("FAIL busy_no_requeue: rdy=%b done=%b oe=%h exp 1/0/00A9",
               cfg_ready, commit_done, oe_bus);
    end
    commit = 1'b1;
    step();
    commit = 1'b0;
    for (int i = 0; i < 3; i++) step();
    vectors++;
    if (oe_bus !== 16'h00A9 || sel_bus !== 64'h0000_0000_D060_3008) begin
      miscompares++;
      $display("FAIL busy_no_write: oe=%h sel=%h exp 00A9/D0603008",
               oe_bus, sel_bus);
    end
    step();
  endtask

  task automatic test_reset_mid();
    write_cfg(4'd3, 4'd6, 1'b1);
    commit = 1'b1;
    step();
    commit = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    vectors++;
    if (sel_bus !== 64'h0 || oe_bus !== 16'h0 ||
        cfg_ready !== 1'b1 || commit_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: sel=%h oe=%h rdy=%b done=%b exp 0/0/1/0",
               sel_bus, oe_bus, cfg_ready, commit_done);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if (commit_done !== 1'b0 || oe_bus !== 16'h0) begin
        miscompares++;
        $display("FAIL reset_mid_after%0d: done=%b oe=%h exp 0/0000",
                 i, commit_done, oe_bus);
      end
    end
  endtask

`ifdef SWITCH_CFG_READBACK_EN
  task automatic test_readback();
    write_cfg(4'd3, 4'd10, 1'b1);
    rd_port = 4'd3;
    commit  = 1'b1;
    step();
    commit  = 1'b0;
    step();
    step();
    vectors++;
    if (rd_src !== 4'd0 || rd_en !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_apply: src=%0d en=%b exp 0/0", rd_src, rd_en);
    end
    step();
    vectors++;
    if (rd_src !== 4'd10 || rd_en !== 1'b1) begin
      miscompares++;
      $display("FAIL rd_idle: src=%0d en=%b exp 10/1", rd_src, rd_en);
    end
    rd_port = 4'd0;
    step();
    vectors++;
    if (rd_src !== 4'd0 || rd_en !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_port0: src=%0d en=%b exp 0/0", rd_src, rd_en);
    end
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    cfg_valid   = 1'b0;
    cfg_port    = 4'd0;
    cfg_src     = 4'd0;
    cfg_en      = 1'b0;
    commit      = 1'b0;
`ifdef SWITCH_CFG_READBACK_EN
    rd_port     = 4'd0;
`endif
    test_reset();
    test_commit_new();
    test_break_before_make();
    test_same_cycle();
    test_last_write_wins();
    test_no_change_commit();
    test_ignored_busy();
    test_reset_mid();
`ifdef SWITCH_CFG_READBACK_EN
    test_readback();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
